fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter c_WR_DATA_WIDTH, default 32, data width of both requesters and the FIFO write port (legal 1..1152).
REQ-002 SHALL have parameter c_BURST_LEN, default 16, maximum beats per grant (legal 1..256).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 wr_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 wr_rst  input  1  synchronous active-high reset, sampled on the wr_clk rising edge.
REQ-006 req0_data  input  c_WR_DATA_WIDTH  requester 0 write data.
REQ-007 req0_en  input  1  requester 0 has a beat to write; also serves as the request.
REQ-008 req0_last  input  1  marks requester 0's final beat of a burst; meaningful only when the beat is accepted.
REQ-009 req0_vld  output  1  requester 0 beat accepted this cycle when req0_en=1.
REQ-010 req1_data, req1_en, req1_last, req1_vld SHALL mirror REQ-006..REQ-009 for requester 1.
REQ-011 fifo_wr_data  output  c_WR_DATA_WIDTH  to the FIFO wr_data port.
REQ-012 fifo_wr_en  output  1  to the FIFO wr_en port.
REQ-013 fifo_wr_vld  input  1  FIFO not-full indication (FIFO wr_vld).
REQ-014 grant  output  2  one-hot current owner: bit0 = requester 0, bit1 = requester 1, 00 = none.
REQ-015 burst_done  output  1  single-cycle pulse on the accepted final beat of a grant.

Function
REQ-016 The FSM SHALL have states IDLE, GNT0 and GNT1, and the grant output SHALL be 00, 01 and 10 in those states respectively.
REQ-017 IDLE SHALL go to GNT0 when req0_en=1 and req1_en=0.
REQ-018 IDLE SHALL go to GNT1 when req1_en=1 and req0_en=0.
REQ-019 IDLE SHALL choose the requester not served last when both req0_en=1 and req1_en=1.
REQ-020 IDLE SHALL stay in IDLE when neither requester asserts en.
REQ-021 Arbitration latency SHALL be exactly one cycle: no beat is accepted in the cycle IDLE decides.
REQ-022 Register last_gnt SHALL record the owner at every transition into GNTx.
REQ-023 In GNTx: reqx_vld = fifo_wr_vld (combinational), and the other requester's vld = 0.
REQ-024 In GNTx: fifo_wr_en = reqx_en & fifo_wr_vld.
REQ-025 In GNTx: fifo_wr_data = reqx_data (combinational mux).
REQ-026 In IDLE: fifo_wr_en = 0, both req vld = 0, fifo_wr_data = 0.
REQ-027 A beat SHALL be accepted iff fifo_wr_en=1; each accepted beat SHALL increment beat_cnt (width ceil(log2(c_BURST_LEN+1))).
REQ-028 The grant SHALL end on an accepted beat with reqx_last=1 or with beat_cnt = c_BURST_LEN-1.
REQ-029 At grant end the FSM SHALL return to IDLE next cycle, clear beat_cnt, and assert burst_done in the same cycle as the final beat.
REQ-030 If the owner drops en mid-grant, the grant SHALL be held without timeout, and fifo_wr_en SHALL stay 0 until en returns.
REQ-031 When fifo_wr_vld=0 (FIFO full), no beat SHALL be accepted and beat_cnt and the state SHALL hold.
REQ-032 When c_BURST_LEN=1, every accepted beat SHALL end the grant.
REQ-033 The FIFO SHALL never be written while fifo_wr_vld=0, and data SHALL never be written from a non-granted requester.
REQ-034 Beats from one grant SHALL never interleave with beats from the other grant.

Reset
REQ-035 On wr_rst=1 at a clock edge: state=IDLE, beat_cnt=0, last_gnt=requester 1 (so requester 0 wins the first tie), grant=00, burst_done=0.
REQ-036 During reset fifo_wr_en, req0_vld and req1_vld SHALL be 0.
REQ-037 Reset asserted mid-grant SHALL abandon the burst, with no further FIFO write from the cycle after the reset edge.

Verification
REQ-038 Tie after reset: req0_en=req1_en=1, fifo_wr_vld=1, last never asserted, c_BURST_LEN=16 -> grant 01 for 16 writes, burst_done on the 16th write, IDLE for 1 cycle, then grant 10 for 16 writes; alternation repeats.
REQ-039 Early last: requester 1 alone, req1_last=1 on the 3rd beat -> exactly 3 FIFO writes, burst_done with the 3rd, grant returns to 00.
REQ-040 Backpressure: during GNT0, fifo_wr_vld=0 for 5 cycles after beat 4 -> fifo_wr_en=0 and req0_vld=0 for those 5 cycles, beat_cnt holds at 4, burst completes with 16 total writes and no loss or duplication.
REQ-041 Owner stall: requester 0 drops en for 7 cycles mid-grant while requester 1 requests -> grant stays 01, requester 1 receives no vld, requester 0 finishes its burst.
REQ-042 Mid-burst reset: wr_rst pulsed for 1 cycle after beat 6 of a GNT1 burst -> grant=00 next cycle, subsequent tie goes to requester 0, beat_cnt restarts at 0.
REQ-043 Scoreboard check in all scenarios: FIFO write order equals per-requester order, contiguous within each grant.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Two-requester write arbiter in front of a single FIFO write port. An idle
// cycle picks an owner, with round-robin on a tie. The owner then streams
// beats straight into the FIFO until it marks a last beat or the burst
// length limit is reached. After that the arbiter returns to idle for one
// cycle before it grants again.
//
// Ports
//   wr_clk        sole clock, rising edge
//   wr_rst        synchronous active-high reset
//   req0_data     requester 0 write data
//   req0_en       requester 0 has a beat (also its request)
//   req0_last     requester 0 final beat of burst (when accepted)
//   req0_vld      requester 0 beat accepted this cycle when req0_en=1
//   req1_*        same as req0_* for requester 1
//   fifo_wr_data  FIFO write data
//   fifo_wr_en    FIFO write enable
//   fifo_wr_vld   FIFO not-full
//   grant         one-hot owner: 01 = req0, 10 = req1, 00 = none
//   burst_done    pulse on the accepted final beat of a grant
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int c_WR_DATA_WIDTH = 32,
  parameter int c_BURST_LEN     = 16
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst,
  input  logic [c_WR_DATA_WIDTH-1:0] req0_data,
  input  logic                       req0_en,
  input  logic                       req0_last,
  output logic                       req0_vld,
  input  logic [c_WR_DATA_WIDTH-1:0] req1_data,
  input  logic                       req1_en,
  input  logic                       req1_last,
  output logic                       req1_vld,
  output logic [c_WR_DATA_WIDTH-1:0] fifo_wr_data,
  output logic                       fifo_wr_en,
  input  logic                       fifo_wr_vld,
  output logic [1:0]                 grant,
  output logic                       burst_done
);

  localparam int c_CNT_W = $clog2(c_BURST_LEN + 1);

  // The state encoding doubles as the one-hot grant value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic [c_CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic                 last_gnt, last_gnt_nxt;   // 1: requester 1 was served last

  logic                       own_en;
  logic                       own_last;
  logic [c_WR_DATA_WIDTH-1:0] own_data;
  logic                       accept;
  logic                       burst_end;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_gnt <= 1'b1;   // requester 0 wins the first tie
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Owner-side view: select the granted requester's signals.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    own_en   = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    case (state)
      GNT0: begin
        own_en   = req0_en;
        own_last = req0_last;
        own_data = req0_data;
      end
      GNT1: begin
        own_en   = req1_en;
        own_last = req1_last;
        own_data = req1_data;
      end
      default: ;
    endcase
  end

  // Reset masks the write immediately, so an abandoned burst writes nothing
  // in the reset cycle itself.
  assign accept    = own_en & fifo_wr_vld & ~wr_rst;
  assign burst_end = accept &
                     (own_last | (beat_cnt == c_CNT_W'(c_BURST_LEN - 1)));

  // Next-state logic. The IDLE decision only takes effect at the next edge,
  // which gives one cycle of arbitration latency with no write.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (req0_en && (!req1_en || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (req1_en) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        // An owner with en low, or a full FIFO, leaves everything held.
        if (burst_end) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + c_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant        = state;
  assign req0_vld     = ~wr_rst & (state == GNT0) & fifo_wr_vld;
  assign req1_vld     = ~wr_rst & (state == GNT1) & fifo_wr_vld;
  assign fifo_wr_en   = accept;
  assign fifo_wr_data = own_data;
  assign burst_done   = burst_end;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed scenarios push the hand-computed write sequence into a scoreboard
// queue. A monitor pops one entry for every FIFO write it observes on the
// falling edge. It compares owner, data and burst_done against that entry.
// Requester data is base + beat index. The index advances only when the
// beat is accepted, so a lost or repeated beat shows up as a wrong data word.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int W = 32;

  logic         wr_clk;
  logic         wr_rst;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_en, req0_last, req0_vld;
  logic         req1_en, req1_last, req1_vld;
  logic [W-1:0] fifo_wr_data;
  logic         fifo_wr_en, fifo_wr_vld;
  logic [1:0]   grant;
  logic         burst_done;

  typedef struct {
    logic [1:0]   gnt;
    logic [W-1:0] data;
    logic         done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   start_cyc;
  int   idx0, idx1;          // next beat index per requester
  int   last_at0, last_at1;  // index carrying last, -1 = never

  assign req0_data = 32'hA000_0000 + 32'(idx0);
  assign req1_data = 32'hB100_0000 + 32'(idx1);
  assign req0_last = (idx0 == last_at0);
  assign req1_last = (idx1 == last_at1);

  fifo_wr_arbiter #(
    .c_WR_DATA_WIDTH(W),
    .c_BURST_LEN    (16)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .req0_data   (req0_data),
    .req0_en     (req0_en),
    .req0_last   (req0_last),
    .req0_vld    (req0_vld),
    .req1_data   (req1_data),
    .req1_en     (req1_en),
    .req1_last   (req1_last),
    .req1_vld    (req1_vld),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_vld (fifo_wr_vld),
    .grant       (grant),
    .burst_done  (burst_done)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int req, input int first, input int n, input bit done_last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.gnt  = (req == 0) ? 2'b01 : 2'b10;
      e.data = ((req == 0) ? 32'hA000_0000 : 32'hB100_0000) + 32'(first + i);
      e.done = done_last && (i == n - 1);
      sb_q.push_back(e);
    end
  endtask

  // Wait for the scoreboard to empty, then check the scenario length in cycles.
  task automatic drain(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge wr_clk); #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      check({name, "_timeout_left"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    check({name, "_cycles"}, 64'(cyc - start_cyc), 64'(exp_cycles));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wr_clk); #1;
    end
  endtask

  // Requester model: advance the beat index when the beat seen on the falling
  // edge is accepted at the following rising edge.
  initial begin : driver
    bit a0, a1;
    forever begin
      @(negedge wr_clk);
      a0 = (req0_en === 1'b1) && (req0_vld === 1'b1);
      a1 = (req1_en === 1'b1) && (req1_vld === 1'b1);
      @(posedge wr_clk); #1;
      if (a0) idx0++;
      if (a1) idx1++;
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge wr_clk);
      if (fifo_wr_en === 1'b1) begin
        check("wr_while_full", fifo_wr_vld, 1'b1);
        if (sb_q.size() == 0) begin
          check("unexpected_write", fifo_wr_data, 64'hDEAD);
        end else begin
          e = sb_q.pop_front();
          check("wr_data",    fifo_wr_data, e.data);
          check("wr_grant",   grant,        e.gnt);
          check("burst_done", burst_done,   e.done);
        end
      end else begin
        check("done_without_write", burst_done, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before t=100000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    wr_rst      = 1'b1;
    req0_en     = 1'b1;
    req1_en     = 1'b1;
    fifo_wr_vld = 1'b1;
    idx0 = 0; idx1 = 0;
    last_at0 = -1; last_at1 = -1;

    // Reset: outputs quiet while requests are asserted.
    @(negedge wr_clk);
    check("rst_wr_en",   fifo_wr_en, 1'b0);
    check("rst_req0_vld", req0_vld,  1'b0);
    check("rst_req1_vld", req1_vld,  1'b0);
    step(1);
    @(negedge wr_clk);
    check("rst_grant",   grant,      2'b00);
    check("rst_done",    burst_done, 1'b0);
    check("rst_wr_en2",  fifo_wr_en, 1'b0);

    // S1: tie after reset, 16-beat bursts alternating 0,1,0.
    step(1);
    wr_rst = 1'b0;
    start_cyc = cyc;
    push(0, 0, 16, 1);
    push(1, 0, 16, 1);
    push(0, 16, 16, 1);
    drain("s1_tie", 51);
    check("s1_idle_after", grant, 2'b00);
    req0_en = 1'b0; req1_en = 1'b0;
    step(2);

    // S2: requester 1 alone, last on its 3rd beat.
    last_at1 = 18;
    req1_en  = 1'b1;
    start_cyc = cyc;
    push(1, 16, 3, 1);
    drain("s2_early_last", 4);
    check("s2_idle_after", grant, 2'b00);
    req1_en = 1'b0;
    step(3);
    last_at1 = -1;

    // S3: backpressure for 5 cycles after beat 4 of a GNT0 burst.
    req0_en = 1'b1;
    start_cyc = cyc;
    push(0, 32, 16, 1);
    step(5);
    fifo_wr_vld = 1'b0;
    repeat (5) begin
      @(negedge wr_clk);
      check("s3_full_wr_en", fifo_wr_en, 1'b0);
      check("s3_full_vld0",  req0_vld,   1'b0);
      check("s3_full_grant", grant,      2'b01);
      step(1);
    end
    fifo_wr_vld = 1'b1;
    drain("s3_backpressure", 22);
    check("s3_idle_after", grant, 2'b00);
    req0_en = 1'b0;
    step(2);

    // S4: owner 0 stalls 7 cycles while requester 1 waits.
    req0_en = 1'b1;
    start_cyc = cyc;
    push(0, 48, 16, 1);
    push(1, 19, 16, 1);
    step(1);
    req1_en = 1'b1;
    step(3);
    req0_en = 1'b0;
    repeat (7) begin
      @(negedge wr_clk);
      check("s4_stall_grant", grant,      2'b01);
      check("s4_stall_vld1",  req1_vld,   1'b0);
      check("s4_stall_vld0",  req0_vld,   1'b1);
      check("s4_stall_wr_en", fifo_wr_en, 1'b0);
      step(1);
    end
    req0_en = 1'b1;
    drain("s4_owner_stall", 41);
    check("s4_idle_after", grant, 2'b00);
    req0_en = 1'b0; req1_en = 1'b0;
    step(2);

    // S5: reset after beat 6 of a GNT1 burst, then a tie.
    req1_en = 1'b1;
    start_cyc = cyc;
    push(1, 35, 6, 0);
    push(0, 64, 16, 1);
    push(1, 41, 16, 1);
    step(7);
    wr_rst  = 1'b1;
    req0_en = 1'b1;
    @(negedge wr_clk);
    check("s5_rst_wr_en", fifo_wr_en, 1'b0);
    check("s5_rst_vld1",  req1_vld,   1'b0);
    step(1);
    wr_rst = 1'b0;
    @(negedge wr_clk);
    check("s5_grant_after_rst", grant, 2'b00);
    drain("s5_mid_reset", 42);
    check("s5_idle_after", grant, 2'b00);
    req0_en = 1'b0; req1_en = 1'b0;
    step(3);

    check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
